fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory request at a time, holds the
// fetched word for a stalling consumer, and drops in-flight fetches on redirects.
module fetch_ctrl #(
  parameter int unsigned           WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_addr,
  output logic                  mem_req,
  output logic [WORD_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  if_valid,
  output logic [WORD_WIDTH-1:0] if_instr,
  output logic [WORD_WIDTH-1:0] if_pc,
  output logic [15:0]           squash_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_OUT,
    S_DISCARD
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic [WORD_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  if_valid_q, if_valid_d;
  logic [WORD_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [WORD_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [CNT_W-1:0]      squash_q, squash_d;
  logic [CNT_W-1:0]      squash_inc;
  logic [WORD_WIDTH-1:0] seq_addr;

  assign squash_inc = (squash_q == {CNT_W{1'b1}}) ? squash_q : squash_q + CNT_W'(1);
  assign seq_addr   = req_addr_q + WORD_WIDTH'(4);

  // Next-state logic; branch_taken outranks mem_ack and stall everywhere.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    squash_d   = squash_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (branch_taken) begin
          pc_d       = branch_addr;
          req_addr_d = branch_addr;
        end else begin
          req_addr_d = pc_q;
        end
      end

      S_REQ: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          if_valid_d = 1'b0;
          if (mem_ack) begin
            squash_d   = squash_inc;
            req_addr_d = branch_addr;
          end else begin
            state_d = S_DISCARD;
          end
        end else if (mem_ack) begin
          if_instr_d = mem_rdata;
          if_pc_d    = seq_addr;
          if_valid_d = 1'b1;
          pc_d       = seq_addr;
          state_d    = S_OUT;
        end
      end

      S_OUT: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          req_addr_d = branch_addr;
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end else if (!stall) begin
          req_addr_d = pc_q;
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end

      S_DISCARD: begin
        if (mem_ack) begin
          squash_d = squash_inc;
          state_d  = S_REQ;
          if (branch_taken) begin
            pc_d       = branch_addr;
            req_addr_d = branch_addr;
          end else begin
            req_addr_d = pc_q;
          end
        end else if (branch_taken) begin
          pc_d = branch_addr;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // mem_req is registered from the next state so it mirrors the Moore decode.
  assign mem_req_d = (state_d == S_REQ) || (state_d == S_DISCARD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      squash_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      mem_req_q  <= mem_req_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      squash_q   <= squash_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = req_addr_q;
  assign if_valid   = if_valid_q;
  assign if_instr   = if_instr_q;
  assign if_pc      = if_pc_q;
  assign squash_cnt = squash_q;

endmodule
